// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS data-memory slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

   // Default data/address width of the datapath.
   localparam int N_BITS = 32;

   // Wait-state controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

endpackage : mips_pkg

// File: rtl/data_mem_unit_if.sv
// Processor-to-data-memory bus: load/store request, address, data, status.
// Latency: n/a (wiring only).
// Backpressure: stall from the memory side holds the processor.
// master = processor (drives request/addr/write_data); slave = data_mem_unit.
interface data_mem_unit_if
   import mips_pkg::*;
#(
   parameter int n_bits = N_BITS
);
   logic              mem_read;
   logic              mem_write;
   logic [n_bits-1:0] addr;
   logic [n_bits-1:0] write_data;
   logic [n_bits-1:0] read_data;
   logic              stall;
   logic              misalign;

   modport master (
      output mem_read, mem_write, addr, write_data,
      input  read_data, stall, misalign
   );

   modport slave (
      input  mem_read, mem_write, addr, write_data,
      output read_data, stall, misalign
   );
endinterface : data_mem_unit_if

// File: rtl/dmem_ram.sv
// Word storage array with synchronous write and synchronous (registered) read.
// Latency: write lands and read data appears on the edge where the enable is high.
// Backpressure: none; enables are single-cycle strobes from the controller.
// Ports: clk, we/re strobes, word address, write data, registered read data.
module dmem_ram #(
   parameter int n_bits = 32,
   parameter int depth  = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     re,
   input  logic [$clog2(depth)-1:0] word_addr,
   input  logic [n_bits-1:0]        wdata,
   output logic [n_bits-1:0]        rdata
);

   // Contents are deliberately not reset.
   logic [n_bits-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[word_addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[word_addr];
      end
   end

endmodule : dmem_ram

// File: rtl/data_mem_unit.sv
// Data memory with programmable wait states for the single-cycle MIPS core.
// Latency: wait_cycles+2 cycles per access; load data valid in the DONE cycle.
// Backpressure: stall (combinational) holds PC / RegWrite while an access is pending.
// Ports: clk, reset (sync, active-high), bus (slave modport of data_mem_unit_if).
// Optional: define DMEM_MISALIGN_CHECK_EN to trap accesses with addr[1:0] != 0.
module data_mem_unit
   import mips_pkg::*;
#(
   parameter int n_bits      = N_BITS,
   parameter int depth       = 64,
   parameter int wait_cycles = 2
) (
   input  logic           clk,
   input  logic           reset,
   data_mem_unit_if.slave bus
);

   localparam int         AW       = $clog2(depth);
   localparam logic [3:0] CNT_INIT = (wait_cycles > 0) ? 4'(wait_cycles - 1) : 4'd0;

   dmem_state_t       state;
   logic [3:0]        cnt;
   logic              req;
   logic              complete;
   logic              mis_addr;
   logic              we;
   logic              re;
   logic              zero_q;     // read_data forced to 0 (after reset / misaligned access)
   logic [n_bits-1:0] ram_rdata;
   logic [AW-1:0]     word_addr;

   assign req       = bus.mem_read | bus.mem_write;
   assign word_addr = bus.addr[AW+1:2];

   // Access happens on the edge that enters DONE; reset on that edge cancels it.
   assign complete = !reset && req &&
                     (((state == IDLE) && (wait_cycles == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0)));

`ifdef DMEM_MISALIGN_CHECK_EN
   logic misalign_q;
   logic unused_addr;

   assign mis_addr     = (bus.addr[1:0] != 2'b00);
   assign bus.misalign = misalign_q;
   assign unused_addr  = ^bus.addr[n_bits-1:AW+2];

   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else if (complete) begin
         misalign_q <= mis_addr;
      end
   end
`else
   logic unused_addr;

   assign mis_addr     = 1'b0;
   assign bus.misalign = 1'b0;
   assign unused_addr  = ^{bus.addr[n_bits-1:AW+2], bus.addr[1:0]};
`endif

   // Simultaneous read+write performs only the write; read_data is left alone.
   assign we = complete && bus.mem_write && !mis_addr;
   assign re = complete && bus.mem_read && !bus.mem_write && !mis_addr;

   dmem_ram #(
      .n_bits (n_bits),
      .depth  (depth)
   ) u_ram (
      .clk       (clk),
      .we        (we),
      .re        (re),
      .word_addr (word_addr),
      .wdata     (bus.write_data),
      .rdata     (ram_rdata)
   );

   // The RAM read register has no reset, so a registered zero flag gives
   // read_data its reset value and the zero load of a trapped access.
   assign bus.read_data = zero_q ? '0 : ram_rdata;
   assign bus.stall     = req && (state != DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         zero_q <= 1'b1;
      end else begin
         if (complete) begin
            if (mis_addr) begin
               zero_q <= 1'b1;
            end else if (re) begin
               zero_q <= 1'b0;
            end
         end

         case (state)
            IDLE: begin
               if (req) begin
                  if (wait_cycles > 0) begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            WAIT: begin
               if (!req) begin
                  state <= IDLE;   // request withdrawn: abort, nothing accessed
                  cnt   <= 4'd0;
               end else if (cnt == 4'd0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule : data_mem_unit

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: one instance with 2 wait states, one with 0.
// Each table row is one clock cycle of processor inputs plus the expected
// stall / read_data / misalign seen mid-cycle.
module tb_data_mem_unit;
   import mips_pkg::*;

`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   typedef struct {
      bit          dut_b;
      bit          rst;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          exp_stall;
      logic [31:0] exp_rdata;
      bit          exp_mis;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   vec_t vecs[$];

   data_mem_unit_if #(.n_bits(32)) bus_a ();
   data_mem_unit_if #(.n_bits(32)) bus_b ();

   data_mem_unit #(.n_bits(32), .depth(64), .wait_cycles(2)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   data_mem_unit #(.n_bits(32), .depth(64), .wait_cycles(0)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
      end
   endtask

   task automatic add(input bit b, input bit rst, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit es, input logic [31:0] er, input bit em);
      vec_t v;
      v.dut_b = b; v.rst = rst; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
      v.exp_stall = es; v.exp_rdata = er; v.exp_mis = em;
      vecs.push_back(v);
   endtask

   // Full access on the 2-wait-state instance: 3 stalled cycles, then DONE.
   task automatic acc2(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] r0, input bit m0, input logic [31:0] r1, input bit m1);
      for (int i = 0; i < 3; i++) add(1'b0, 1'b0, rd, wr, a, d, 1'b1, r0, m0);
      add(1'b0, 1'b0, rd, wr, a, d, 1'b0, r1, m1);
   endtask

   // Full access on the 0-wait-state instance: 1 stalled cycle, then DONE.
   task automatic acc0(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] r0, input logic [31:0] r1);
      add(1'b1, 1'b0, rd, wr, a, d, 1'b1, r0, 1'b0);
      add(1'b1, 1'b0, rd, wr, a, d, 1'b0, r1, 1'b0);
   endtask

   task automatic drive_idle();
      bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0; bus_a.addr = '0; bus_a.write_data = '0;
      bus_b.mem_read = 1'b0; bus_b.mem_write = 1'b0; bus_b.addr = '0; bus_b.write_data = '0;
   endtask

   initial begin
      logic [31:0] r_mis;
      logic [31:0] r1;
      vec_t        v;

      checks   = 0;
      failures = 0;

      r_mis = MIS ? 32'h0 : 32'h55;
      r1    = MIS ? 32'd30 : 32'h77;

      // ---- wait_cycles = 2 instance ----
      acc2(1'b0, 1'b1, 32'h10, 32'd30, 32'd0, 1'b0, 32'd0, 1'b0);
      acc2(1'b1, 1'b0, 32'h10, 32'd0, 32'd0, 1'b0, 32'd30, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd30, 1'b0);
      // 0x100 wraps onto word 0 with depth 64
      acc2(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'd30, 1'b0, 32'd30, 1'b0);
      acc2(1'b1, 1'b0, 32'h0, 32'h0, 32'd30, 1'b0, 32'hDEADBEEF, 1'b0);
      // read+write together: write happens, read_data unchanged
      acc2(1'b1, 1'b1, 32'h20, 32'h55, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
      acc2(1'b1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 32'h55, 1'b0);
      // misaligned store to 0x12, then aligned load of 0x10
      acc2(1'b0, 1'b1, 32'h12, 32'h77, 32'h55, 1'b0, r_mis, MIS);
      acc2(1'b1, 1'b0, 32'h10, 32'h0, r_mis, MIS, r1, 1'b0);
      // store to 0x20 withdrawn while waiting
      add(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h99, 1'b1, r1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h99, 1'b1, r1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, r1, 1'b0);
      acc2(1'b1, 1'b0, 32'h20, 32'h0, r1, 1'b0, 32'h55, 1'b0);
      // store to 0x20 cut by reset in the last wait cycle
      add(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hAA, 1'b1, 32'h55, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hAA, 1'b1, 32'h55, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'hAA, 1'b1, 32'h55, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      acc2(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 32'h55, 1'b0);

      // ---- wait_cycles = 0 instance, back-to-back accesses ----
      acc0(1'b0, 1'b1, 32'h0, 32'd1, 32'd0, 32'd0);
      acc0(1'b0, 1'b1, 32'h4, 32'd2, 32'd0, 32'd0);
      acc0(1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 32'd1);
      acc0(1'b1, 1'b0, 32'h4, 32'h0, 32'd1, 32'd2);
      add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd2, 1'b0);

      // ---- reset held two cycles ----
      drive_idle();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_rdata_a", -1, bus_a.read_data, 32'h0);
      chk("reset_mis_a",   -1, {31'h0, bus_a.misalign}, 32'h0);
      chk("reset_stall_a", -1, {31'h0, bus_a.stall}, 32'h0);
      chk("reset_rdata_b", -1, bus_b.read_data, 32'h0);
      chk("reset_stall_b", -1, {31'h0, bus_b.stall}, 32'h0);

      // ---- table ----
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(posedge clk);
         #1;
         drive_idle();
         reset = v.rst;
         if (v.dut_b) begin
            bus_b.mem_read = v.rd; bus_b.mem_write = v.wr;
            bus_b.addr = v.addr;   bus_b.write_data = v.wdata;
         end else begin
            bus_a.mem_read = v.rd; bus_a.mem_write = v.wr;
            bus_a.addr = v.addr;   bus_a.write_data = v.wdata;
         end
         @(negedge clk);
         if (v.dut_b) begin
            chk("stall_b", i, {31'h0, bus_b.stall}, {31'h0, v.exp_stall});
            chk("rdata_b", i, bus_b.read_data, v.exp_rdata);
            chk("mis_b",   i, {31'h0, bus_b.misalign}, {31'h0, v.exp_mis});
         end else begin
            chk("stall_a", i, {31'h0, bus_a.stall}, {31'h0, v.exp_stall});
            chk("rdata_a", i, bus_a.read_data, v.exp_rdata);
            chk("mis_a",   i, {31'h0, bus_a.misalign}, {31'h0, v.exp_mis});
         end
      end

      @(posedge clk);
      #1;
      drive_idle();
      reset = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_data_mem_unit
